// File: rtl/tag_mem_array.sv
// Tag memory responder: three word banks (EPC, sensor1, sensor2) behind a
// precharge/sense/write handshake, with factory-clear sweep and protocol-error flagging.
module tag_mem_array #(
  parameter int                 DATA_W      = 16,
  parameter int                 ADDR_W      = 6,
  parameter int                 DEPTH       = 64,
  parameter int                 SENSE_LAT   = 1,
  parameter int                 ARM_TIMEOUT = 8,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              factory_reset,
  input  logic              PC_B,
  input  logic              SE,
  input  logic              WE,
  input  logic [2:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_read_in,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              acc_err,
  output logic              busy
);

  localparam int CNT_W = (SENSE_LAT > 1) ? $clog2(SENSE_LAT) : 1;
  localparam int TMR_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(SENSE_LAT - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ARM_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_SENSE, S_HOLD, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_done_q, wr_done_d;
  logic                acc_err_q, acc_err_d;
  logic                busy_q, busy_d;
  logic                wr_en, clr_en;
  logic [DATA_W-1:0]   rd_word;

  logic [DATA_W-1:0] bank_epc [DEPTH];
  logic [DATA_W-1:0] bank_s1  [DEPTH];
  logic [DATA_W-1:0] bank_s2  [DEPTH];

  function automatic logic req_ok(input logic [2:0] sel, input logic [ADDR_W-1:0] addr);
    return ((sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100)) && (int'(addr) < DEPTH);
  endfunction

  always_comb begin
    if (sel_q[0])      rd_word = bank_epc[addr_q];
    else if (sel_q[1]) rd_word = bank_s1[addr_q];
    else               rd_word = bank_s2[addr_q];
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    acc_err_d  = 1'b0;
    busy_d     = busy_q;
    wr_en      = 1'b0;
    clr_en     = 1'b0;
    if (factory_reset) begin
      state_d = S_CLEAR;
      idx_d   = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!PC_B) begin
            sel_d   = mem_sel;
            addr_d  = mem_address;
            state_d = S_PRE;
          end else if (SE || WE) begin
            acc_err_d = 1'b1;
          end
        end
        S_PRE, S_ARMED: begin
          if (!PC_B) begin
            sel_d   = mem_sel;
            addr_d  = mem_address;
            state_d = S_PRE;
          end else if (!req_ok(sel_q, addr_q) || (SE && WE)) begin
            acc_err_d = 1'b1;
            state_d   = S_IDLE;
          end else if (WE) begin
            wr_en     = 1'b1;
            wr_done_d = 1'b1;
            state_d   = S_HOLD;
          end else if (SE) begin
            cnt_d   = CNT_INIT;
            state_d = S_SENSE;
          end else if (state_q == S_PRE) begin
            tmr_d   = '0;
            state_d = S_ARMED;
          end else if (tmr_q == TMR_LAST) begin
            acc_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        S_SENSE: begin
          // Losing SE or seeing WE mid-sense aborts without touching the read register.
          if (WE || !SE) begin
            acc_err_d = 1'b1;
            state_d   = S_IDLE;
          end else if (cnt_q == '0) begin
            rdata_d    = rd_word;
            rd_valid_d = 1'b1;
            state_d    = S_HOLD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (!PC_B) begin
            sel_d   = mem_sel;
            addr_d  = mem_address;
            state_d = S_PRE;
          end else if (!SE && !WE) begin
            state_d = S_IDLE;
          end
        end
        S_CLEAR: begin
          clr_en = 1'b1;
          if (idx_q == IDX_LAST) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      idx_q      <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      acc_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      acc_err_q  <= acc_err_d;
      busy_q     <= busy_d;
    end
  end

  // Array storage has no reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      bank_epc[idx_q] <= CLEAR_VALUE;
      bank_s1[idx_q]  <= CLEAR_VALUE;
      bank_s2[idx_q]  <= CLEAR_VALUE;
    end else if (wr_en) begin
      if (sel_q[0]) bank_epc[addr_q] <= mem_data_in;
      if (sel_q[1]) bank_s1[addr_q]  <= mem_data_in;
      if (sel_q[2]) bank_s2[addr_q]  <= mem_data_in;
    end
  end

  assign mem_read_in = rdata_q;
  assign rd_valid    = rd_valid_q;
  assign wr_done     = wr_done_q;
  assign acc_err     = acc_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tag_mem_array.sv
// Bench for tag_mem_array: word-level bank model, randomized accesses, protocol and clear scenarios.
module tb_tag_mem_array;
  localparam int DW = 16, AW = 6, DEPTH = 64, TMO = 8;
  localparam logic [DW-1:0] CLR = 16'h0000;

  logic clk = 1'b0, reset_n = 1'b0, factory_reset = 1'b0;
  logic PC_B = 1'b1, SE = 1'b0, WE = 1'b0;
  logic [2:0]    mem_sel = '0;
  logic [AW-1:0] mem_address = '0;
  logic [DW-1:0] mem_data_in = '0;
  logic [DW-1:0] mem_read_in, rd3;
  logic rd_valid, wr_done, acc_err, busy, rv3, wd3, ae3, bz3;

  int checks = 0, failures = 0;
  logic [DW-1:0] mdl [3][DEPTH];
  bit            written [3][DEPTH];

  always #5 clk = ~clk;

  tag_mem_array #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .SENSE_LAT(1),
                  .ARM_TIMEOUT(TMO), .CLEAR_VALUE(CLR)) dut (
    .clk(clk), .reset_n(reset_n), .factory_reset(factory_reset), .PC_B(PC_B), .SE(SE), .WE(WE),
    .mem_sel(mem_sel), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_in(mem_read_in), .rd_valid(rd_valid), .wr_done(wr_done), .acc_err(acc_err), .busy(busy));

  tag_mem_array #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .SENSE_LAT(3),
                  .ARM_TIMEOUT(TMO), .CLEAR_VALUE(CLR)) dut3 (
    .clk(clk), .reset_n(reset_n), .factory_reset(factory_reset), .PC_B(PC_B), .SE(SE), .WE(WE),
    .mem_sel(mem_sel), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read_in(rd3), .rd_valid(rv3), .wr_done(wd3), .acc_err(ae3), .busy(bz3));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int b, input int a, input logic [DW-1:0] d,
                    output logic done_now, output logic done_next);
    PC_B = 1'b0; mem_sel = 3'(1 << b); mem_address = AW'(a); step();
    PC_B = 1'b1; WE = 1'b1; mem_data_in = d; step();
    done_now = wr_done;
    WE = 1'b0; step();
    done_next = wr_done;
    mdl[b][a] = d;
    written[b][a] = 1'b1;
  endtask

  task automatic rd(input int b, input int a, output int lat1, output logic [DW-1:0] d1,
                    output int lat3, output logic [DW-1:0] d3, output int pulses);
    lat1 = -1; lat3 = -1; d1 = '0; d3 = '0; pulses = 0;
    PC_B = 1'b0; mem_sel = 3'(1 << b); mem_address = AW'(a); step();
    PC_B = 1'b1; SE = 1'b1; step();
    for (int i = 1; i <= 4; i++) begin
      step();
      if (rd_valid) begin
        pulses++;
        if (lat1 < 0) begin lat1 = i; d1 = mem_read_in; end
      end
      if (rv3 && lat3 < 0) begin lat3 = i; d3 = rd3; end
    end
    SE = 1'b0; step();
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (mem_read_in !== '0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", mem_read_in); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (wr_done !== 1'b0) begin failures++; $display("FAIL reset_wr_done got=%b exp=0", wr_done); end
    checks++; if (acc_err !== 1'b0) begin failures++; $display("FAIL reset_acc_err got=%b exp=0", acc_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1; step();
  endtask

  task automatic test_write_read();
    logic dn, dx; int l1, l3, p; logic [DW-1:0] d1, d3;
    wr(0, 5, 16'hA5C3, dn, dx);
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL wr_done_pulse got=%b exp=1", dn); end
    checks++; if (dx !== 1'b0) begin failures++; $display("FAIL wr_done_width got=%b exp=0", dx); end
    rd(0, 5, l1, d1, l3, d3, p);
    checks++; if (l1 !== 1) begin failures++; $display("FAIL rd_latency1 got=%0d exp=1", l1); end
    checks++; if (d1 !== 16'hA5C3) begin failures++; $display("FAIL rd_data got=%0h exp=a5c3", d1); end
    checks++; if (p !== 1) begin failures++; $display("FAIL rd_valid_pulses got=%0d exp=1", p); end
    checks++; if (l3 !== 3 || d3 !== 16'hA5C3) begin failures++; $display("FAIL rd_latency3 got=%0d/%0h exp=3/a5c3", l3, d3); end
  endtask

  task automatic test_bank_isolation();
    logic dn, dx; int l1, l3, p; logic [DW-1:0] d1, d3;
    wr(0, 0, 16'($urandom), dn, dx);
    wr(1, 0, 16'h1234, dn, dx);
    wr(2, 0, 16'h5678, dn, dx);
    for (int b = 0; b < 3; b++) begin
      rd(b, 0, l1, d1, l3, d3, p);
      checks++; if (d1 !== mdl[b][0]) begin failures++; $display("FAIL bank_iso_b%0d got=%0h exp=%0h", b, d1, mdl[b][0]); end
    end
  endtask

  task automatic test_protocol_errors();
    logic dn, dx, e1, e2; int l1, l3, p, n; logic [DW-1:0] d1, d3;
    wr(0, 7, 16'h0F0F, dn, dx);
    wr(1, 7, 16'hF0F0, dn, dx);
    PC_B = 1'b0; mem_sel = 3'b011; mem_address = 7; step();
    PC_B = 1'b1; WE = 1'b1; mem_data_in = 16'hFFFF; step();
    checks++; if (acc_err !== 1'b1 || wr_done !== 1'b0) begin failures++; $display("FAIL bad_sel got=%b%b exp=10", acc_err, wr_done); end
    WE = 1'b0; step();
    for (int b = 0; b < 2; b++) begin
      rd(b, 7, l1, d1, l3, d3, p);
      checks++; if (d1 !== mdl[b][7]) begin failures++; $display("FAIL bad_sel_nowrite_b%0d got=%0h exp=%0h", b, d1, mdl[b][7]); end
    end
    PC_B = 1'b0; mem_sel = 3'b001; mem_address = 7; step();
    PC_B = 1'b1; SE = 1'b1; WE = 1'b1; mem_data_in = 16'h1111; step();
    checks++; if (acc_err !== 1'b1) begin failures++; $display("FAIL se_we_err got=%b exp=1", acc_err); end
    SE = 1'b0; WE = 1'b0; step();
    checks++; if (rd_valid !== 1'b0 || wr_done !== 1'b0) begin failures++; $display("FAIL se_we_noacc got=%b%b exp=00", rd_valid, wr_done); end
    rd(0, 7, l1, d1, l3, d3, p);
    checks++; if (d1 !== mdl[0][7]) begin failures++; $display("FAIL se_we_nowrite got=%0h exp=%0h", d1, mdl[0][7]); end
    SE = 1'b1; step(); e1 = acc_err;
    SE = 1'b0; step(); e2 = acc_err;
    checks++; if (e1 !== 1'b1 || e2 !== 1'b0) begin failures++; $display("FAIL se_no_pre got=%b%b exp=10", e1, e2); end
    PC_B = 1'b0; mem_sel = 3'b001; mem_address = 0; step();
    PC_B = 1'b1; n = 0;
    while (n < 20) begin
      step(); n++;
      if (acc_err) break;
    end
    checks++; if (n !== TMO + 1) begin failures++; $display("FAIL arm_timeout got=%0d exp=%0d", n, TMO + 1); end
    step();
  endtask

  task automatic test_abort_read();
    int l1, l3, p, seen; logic [DW-1:0] d1, d3, prev;
    rd(0, 5, l1, d1, l3, d3, p);
    prev = d3;
    checks++; if (prev !== mdl[0][5]) begin failures++; $display("FAIL abort_preread got=%0h exp=%0h", prev, mdl[0][5]); end
    PC_B = 1'b0; mem_sel = 3'b010; mem_address = 0; step();
    PC_B = 1'b1; SE = 1'b1; step();
    SE = 1'b0; step();
    checks++; if (ae3 !== 1'b1) begin failures++; $display("FAIL abort_err got=%b exp=1", ae3); end
    seen = rv3 ? 1 : 0;
    for (int i = 0; i < 5; i++) begin step(); if (rv3) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_rd_valid got=%0d exp=0", seen); end
    checks++; if (rd3 !== prev) begin failures++; $display("FAIL abort_rdata got=%0h exp=%0h", rd3, prev); end
  endtask

  task automatic test_back_to_back();
    logic w1, w2; int extra, l1, l3, p; logic [DW-1:0] a, b, d1, d3;
    a = 16'($urandom); b = 16'($urandom);
    PC_B = 1'b0; mem_sel = 3'b010; mem_address = 20; step();
    PC_B = 1'b1; WE = 1'b1; mem_data_in = a; step(); w1 = wr_done;
    PC_B = 1'b0; mem_address = 21; step();
    PC_B = 1'b1; mem_data_in = b; step(); w2 = wr_done;
    extra = 0;
    for (int i = 0; i < 3; i++) begin mem_data_in = ~b; step(); if (wr_done) extra++; end
    WE = 1'b0; step();
    mdl[1][20] = a; mdl[1][21] = b; written[1][20] = 1'b1; written[1][21] = 1'b1;
    checks++; if (w1 !== 1'b1 || w2 !== 1'b1) begin failures++; $display("FAIL b2b_wr_done got=%b%b exp=11", w1, w2); end
    checks++; if (extra !== 0) begin failures++; $display("FAIL hold_no_rewrite got=%0d exp=0", extra); end
    rd(1, 20, l1, d1, l3, d3, p);
    checks++; if (d1 !== a) begin failures++; $display("FAIL b2b_word0 got=%0h exp=%0h", d1, a); end
    rd(1, 21, l1, d1, l3, d3, p);
    checks++; if (d1 !== b) begin failures++; $display("FAIL b2b_word1 got=%0h exp=%0h", d1, b); end
  endtask

  task automatic test_random();
    logic dn, dx; int l1, l3, p, bk, ad; logic [DW-1:0] d1, d3;
    for (int k = 0; k < 40; k++) begin
      bk = int'($urandom_range(2)); ad = int'($urandom_range(DEPTH - 1));
      if ($urandom_range(1) == 0 || !written[bk][ad]) begin
        wr(bk, ad, 16'($urandom), dn, dx);
        checks++; if (dn !== 1'b1) begin failures++; $display("FAIL rand_wr_done b%0d a%0d got=%b exp=1", bk, ad, dn); end
      end else begin
        rd(bk, ad, l1, d1, l3, d3, p);
        checks++;
        if (l1 !== 1 || d1 !== mdl[bk][ad] || l3 !== 3 || d3 !== mdl[bk][ad]) begin
          failures++;
          $display("FAIL rand_rd b%0d a%0d got=%0d/%0h,%0d/%0h exp=1/%0h,3", bk, ad, l1, d1, l3, d3, mdl[bk][ad]);
        end
      end
    end
  endtask

  task automatic test_factory_clear();
    logic dn, dx; int n, errs, l1, l3, p; logic [DW-1:0] d1, d3;
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < DEPTH; a++) wr(b, a, 16'($urandom) | 16'h0001, dn, dx);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        PC_B = 1'b0; mem_sel = 3'b001; mem_address = 3; step();
        PC_B = 1'b1; WE = 1'b1; mem_data_in = 16'hBEEF;
      end
      factory_reset = 1'b1; step();
      WE = 1'b0;
      if (pass == 0) begin
        checks++; if (wr_done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL clear_discard got=%b%b exp=01", wr_done, busy); end
      end
      n = 0; errs = 0;
      while (busy && n < 300) begin
        n++;
        if (pass == 0 && n < 50) begin PC_B = 1'($urandom); SE = 1'($urandom); WE = 1'($urandom); end
        else begin PC_B = 1'b1; SE = 1'b0; WE = 1'b0; end
        factory_reset = (pass == 1 && n == 30);
        step();
        if (acc_err) errs++;
      end
      factory_reset = 1'b0;
      checks++;
      if (n !== ((pass == 0) ? DEPTH : 30 + DEPTH)) begin
        failures++; $display("FAIL clear_busy_len pass%0d got=%0d exp=%0d", pass, n, (pass == 0) ? DEPTH : 30 + DEPTH);
      end
      checks++; if (errs !== 0) begin failures++; $display("FAIL clear_no_err pass%0d got=%0d exp=0", pass, errs); end
      step();
    end
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < DEPTH; a++) mdl[b][a] = CLR;
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < DEPTH; a++) begin
        rd(b, a, l1, d1, l3, d3, p);
        checks++; if (d1 !== mdl[b][a]) begin failures++; $display("FAIL clear_word b%0d a%0d got=%0h exp=%0h", b, a, d1, mdl[b][a]); end
      end
  endtask

  task automatic test_reset_sense();
    logic dn, dx; int l1, l3, p; logic [DW-1:0] d1, d3, v;
    v = 16'($urandom) | 16'h8000;
    wr(2, 9, v, dn, dx);
    rd(2, 9, l1, d1, l3, d3, p);
    PC_B = 1'b0; mem_sel = 3'b100; mem_address = 9; step();
    PC_B = 1'b1; SE = 1'b1; step();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (mem_read_in !== '0 || rd_valid !== 1'b0 || acc_err !== 1'b0 || busy !== 1'b0 || rd3 !== '0 || rv3 !== 1'b0) begin
      failures++; $display("FAIL reset_mid_sense got=%0h/%b/%b/%0h exp=0/0/0/0", mem_read_in, rd_valid, acc_err, rd3);
    end
    SE = 1'b0; step(); step();
    checks++; if (rd_valid !== 1'b0 || rv3 !== 1'b0) begin failures++; $display("FAIL reset_no_read got=%b%b exp=00", rd_valid, rv3); end
    reset_n = 1'b1; step();
    rd(2, 9, l1, d1, l3, d3, p);
    checks++; if (l1 !== 1 || d1 !== v) begin failures++; $display("FAIL post_reset_read got=%0d/%0h exp=1/%0h", l1, d1, v); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bank_isolation();
    test_protocol_errors();
    test_abort_read();
    test_back_to_back();
    test_random();
    test_factory_clear();
    test_reset_sense();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
